// File: rtl/rx_frame_parser_pkg.sv
// Shared definitions for the frame receive/transmit path.
//   - state_t   : parser states; the first seven follow the on-wire field order
//                 (ID_1, ID_2, CNT_1, CNT_2, payload, CRC_1, CRC_2)
//   - field_t   : on-wire frame field order, for the transmit generator
//   - CRC_POLY  : reflected CRC-16/MODBUS polynomial
//   - CRC_INIT  : CRC seed at the start of each frame
package rx_frame_parser_pkg;

    typedef enum logic [2:0] {
        S_ID1   = 3'd0,
        S_ID2   = 3'd1,
        S_CNT1  = 3'd2,
        S_CNT2  = 3'd3,
        S_DATA  = 3'd4,
        S_CRC1  = 3'd5,
        S_CRC2  = 3'd6,
        S_CHECK = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        FLD_ID1     = 3'd0,
        FLD_ID2     = 3'd1,
        FLD_CNT1    = 3'd2,
        FLD_CNT2    = 3'd3,
        FLD_PAYLOAD = 3'd4,
        FLD_CRC1    = 3'd5,
        FLD_CRC2    = 3'd6
    } field_t;

    localparam logic [15:0] CRC_POLY = 16'hA001;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/rx_frame_parser_crc16.sv
// crc16_modbus_byte: one-byte CRC-16/MODBUS update, purely combinational.
//   crc_in    [15:0] running CRC before this byte
//   data_byte [7:0]  byte to fold in (LSB first, reflected algorithm)
//   crc_out   [15:0] running CRC after this byte
module crc16_modbus_byte
    import rx_frame_parser_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_byte,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    // NOTE: blocking assignments here are intentional: each loop iteration
    // must see the value produced by the previous one within the same evaluation.
    always_comb begin
        c = crc_in ^ {8'h00, data_byte};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/rx_frame_parser.sv
// rx_frame_parser: recovers addressed command frames from a byte stream.
// Frame: ID_1 ID_2 CNT_1 CNT_2 payload[0..LEN-1] CRC_1 CRC_2, CRC-16/MODBUS
// over ID_1..last payload byte, CRC sent high byte first.
//   sys_clk       clock, rising edge
//   sys_rst       asynchronous active-low reset
//   rx_data       received byte, qualified by rx_data_flag
//   rx_data_flag  one-cycle pulse per received byte
//   cmd           payload byte 0 of the last valid frame (held)
//   cmd_flag      one-cycle pulse when cmd is updated
//   frame_err     one-cycle pulse on bad length, bad CRC or inter-byte timeout
module rx_frame_parser
    import rx_frame_parser_pkg::*;
#(
    parameter logic [15:0] DEV_ID      = 16'h0000,
    parameter int          MAX_LEN     = 8,
    parameter int          TIMEOUT_CYC = 50000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] rx_data,
    input  logic       rx_data_flag,
    output logic [7:0] cmd,
    output logic       cmd_flag,
    output logic       frame_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    state_t           state, state_nxt;
    logic             cmd_flag_d, frame_err_d;
    logic [15:0]      crc_q, crc_rx, crc_in, crc_upd;
    logic [15:0]      len_q, byte_cnt;
    logic [7:0]       cnt_hi, shadow;
    logic [TMO_W-1:0] tmo_cnt;

    // S_CHECK doubles as an ID_1 hunting state so back-to-back frames are not lost.
    logic        hunt_state;
    logic        id1_hit;
    logic        tmo_hit;
    logic [15:0] len_now;

    assign hunt_state = (state == S_ID1) || (state == S_CHECK);
    assign id1_hit    = rx_data_flag && (rx_data == DEV_ID[15:8]);
    assign len_now    = {cnt_hi, rx_data};
    // Expires on the cycle the idle count would reach TIMEOUT_CYC; S_CHECK
    // is excluded so it always yields exactly one verdict pulse.
    assign tmo_hit    = (state != S_ID1) && (state != S_CHECK) && !rx_data_flag &&
                        (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // A new frame restarts from the seed rather than the running value.
    assign crc_in = hunt_state ? CRC_INIT : crc_q;

    crc16_modbus_byte u_crc (
        .crc_in    (crc_in),
        .data_byte (rx_data),
        .crc_out   (crc_upd)
    );

    // NOTE: state, pulses and datapath registers use non-blocking assignments
    // so every flop samples pre-edge values regardless of process order.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state     <= S_ID1;
            cmd_flag  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_flag  <= cmd_flag_d;
            frame_err <= frame_err_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        cmd_flag_d  = 1'b0;
        frame_err_d = 1'b0;
        if (tmo_hit) begin
            state_nxt   = S_ID1;
            frame_err_d = 1'b1;
        end else begin
            case (state)
                S_ID1:  if (id1_hit) state_nxt = S_ID2;
                S_ID2:  if (rx_data_flag)
                            state_nxt = (rx_data == DEV_ID[7:0]) ? S_CNT1 : S_ID1;
                S_CNT1: if (rx_data_flag) state_nxt = S_CNT2;
                S_CNT2: if (rx_data_flag) begin
                            if (len_now == 16'd0 || len_now > 16'(MAX_LEN)) begin
                                state_nxt   = S_ID1;
                                frame_err_d = 1'b1;
                            end else begin
                                state_nxt = S_DATA;
                            end
                        end
                S_DATA: if (rx_data_flag && byte_cnt == len_q - 16'd1) state_nxt = S_CRC1;
                S_CRC1: if (rx_data_flag) state_nxt = S_CRC2;
                S_CRC2: if (rx_data_flag) state_nxt = S_CHECK;
                S_CHECK: begin
                    if (crc_rx == crc_q) cmd_flag_d  = 1'b1;
                    else                 frame_err_d = 1'b1;
                    state_nxt = id1_hit ? S_ID2 : S_ID1;
                end
                default: state_nxt = S_ID1;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            crc_q    <= CRC_INIT;
            crc_rx   <= '0;
            len_q    <= '0;
            byte_cnt <= '0;
            cnt_hi   <= '0;
            shadow   <= '0;
            cmd      <= '0;
            tmo_cnt  <= '0;
        end else begin
            if (hunt_state) begin
                if (id1_hit) crc_q <= crc_upd;
            end else if (rx_data_flag && (state == S_ID2 || state == S_CNT1 ||
                                          state == S_CNT2 || state == S_DATA)) begin
                crc_q <= crc_upd;
            end

            if (rx_data_flag) begin
                case (state)
                    S_CNT1: cnt_hi <= rx_data;
                    S_CNT2: begin
                        len_q    <= len_now;
                        byte_cnt <= '0;
                    end
                    S_DATA: begin
                        if (byte_cnt == 16'd0) shadow <= rx_data;
                        byte_cnt <= byte_cnt + 16'd1;
                    end
                    S_CRC1: crc_rx[15:8] <= rx_data;
                    S_CRC2: crc_rx[7:0]  <= rx_data;
                    default: ;
                endcase
            end

            if (cmd_flag_d) cmd <= shadow;

            if (rx_data_flag || state == S_ID1 || tmo_hit) tmo_cnt <= '0;
            else                                           tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

endmodule

// File: tb/tb_rx_frame_parser.sv
// Scoreboard bench for rx_frame_parser (DEV_ID=0, MAX_LEN=8, TIMEOUT_CYC=100).
// The sender pushes expected pulses (kind, cmd value, cycle) when it drives
// the triggering byte; an independent monitor pops them on each output pulse.
module tb_rx_frame_parser;

    localparam int TMO = 100;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_data_flag = 1'b0;
    logic [7:0] cmd;
    logic       cmd_flag;
    logic       frame_err;

    logic [15:0] kat_in;
    logic [7:0]  kat_byte;
    logic [15:0] kat_out;

    rx_frame_parser #(
        .DEV_ID      (16'h0000),
        .MAX_LEN     (8),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .rx_data      (rx_data),
        .rx_data_flag (rx_data_flag),
        .cmd          (cmd),
        .cmd_flag     (cmd_flag),
        .frame_err    (frame_err)
    );

    crc16_modbus_byte u_kat (
        .crc_in    (kat_in),
        .data_byte (kat_byte),
        .crc_out   (kat_out)
    );

    always #5 sys_clk = ~sys_clk;

    int edge_cnt = 0;
    always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit         is_err;
        logic [7:0] cmd;
        int         at_edge;
    } exp_t;

    typedef struct {
        int         idx;
        bit         is_err;
        logic [7:0] cmd;
        int         offset;
    } trig_t;

    exp_t       exp_q[$];
    trig_t      trig_q[$];
    logic [7:0] tx_q[$];

    // Monitor: compares every output pulse against the head of the scoreboard
    // and flags any expected pulse whose cycle has passed unseen.
    always @(negedge sys_clk) begin
        if (sys_rst === 1'b1) begin
            if (exp_q.size() > 0 && edge_cnt > exp_q[0].at_edge) begin
                check("pulse_missing", edge_cnt, exp_q[0].at_edge);
                void'(exp_q.pop_front());
            end
            if (cmd_flag || frame_err) begin
                check("pulse_exclusive", {31'd0, cmd_flag & frame_err}, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, cmd_flag, frame_err}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pulse_kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
                    check("pulse_cmd", {24'd0, cmd}, {24'd0, e.cmd});
                    check("pulse_cycle", edge_cnt, e.at_edge);
                end
            end
        end
    end

    function automatic logic [15:0] crc_model(input logic [7:0] q[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (q[i]) begin
            c ^= {8'h00, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // Appends a DEV_ID=0 frame with LEN bytes p0, p0+1, ... to tx_q.
    task automatic add_frame(input int len, input logic [7:0] p0, input bit corrupt);
        logic [7:0]  f[$];
        logic [15:0] c;
        f = {8'h00, 8'h00, 8'(len >> 8), 8'(len)};
        for (int i = 0; i < len; i++) f.push_back(p0 + 8'(i));
        c = crc_model(f);
        f.push_back(c[15:8]);
        f.push_back(c[7:0] ^ {7'd0, corrupt});
        foreach (f[i]) tx_q.push_back(f[i]);
    endtask

    task automatic expect_at(input int idx, input bit is_err, input logic [7:0] c, input int off);
        trig_t t;
        t.idx = idx; t.is_err = is_err; t.cmd = c; t.offset = off;
        trig_q.push_back(t);
    endtask

    // Drives tx_q; gapped mode leaves one idle cycle between bytes.
    task automatic send(input bit contiguous);
        for (int i = 0; i < tx_q.size(); i++) begin
            @(negedge sys_clk);
            rx_data      = tx_q[i];
            rx_data_flag = 1'b1;
            foreach (trig_q[k]) begin
                if (trig_q[k].idx == i) begin
                    exp_t e;
                    e.is_err  = trig_q[k].is_err;
                    e.cmd     = trig_q[k].cmd;
                    e.at_edge = edge_cnt + 1 + trig_q[k].offset;
                    exp_q.push_back(e);
                end
            end
            if (!contiguous) begin
                @(negedge sys_clk);
                rx_data_flag = 1'b0;
            end
        end
        @(negedge sys_clk);
        rx_data_flag = 1'b0;
        tx_q   = {};
        trig_q = {};
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        logic [7:0]  kat_str[9];
        logic [15:0] c;

        repeat (3) @(negedge sys_clk);
        check("reset_cmd", {24'd0, cmd}, 0);
        check("reset_cmd_flag", {31'd0, cmd_flag}, 0);
        check("reset_frame_err", {31'd0, frame_err}, 0);
        sys_rst = 1'b1;
        idle(2);

        // Known-answer vector for the CRC byte step: "123456789" -> 0x4B37.
        kat_str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        c = 16'hFFFF;
        for (int i = 0; i < 9; i++) begin
            kat_in = c; kat_byte = kat_str[i];
            #1;
            c = kat_out;
        end
        check("crc_kat_123456789", {16'd0, c}, 32'h4B37);

        // Valid single-byte frame, then the same frame with a bad CRC_2.
        add_frame(1, 8'hA5, 1'b0); expect_at(6, 1'b0, 8'hA5, 1); send(1'b0); idle(5);
        add_frame(1, 8'hA5, 1'b1); expect_at(6, 1'b1, 8'hA5, 1); send(1'b0); idle(5);

        // Length 0 and length MAX_LEN+1 rejected right after CNT_2.
        tx_q = {8'h00, 8'h00, 8'h00, 8'h00}; expect_at(3, 1'b1, 8'hA5, 0); send(1'b0); idle(5);
        tx_q = {8'h00, 8'h00, 8'h00, 8'h09}; expect_at(3, 1'b1, 8'hA5, 0); send(1'b0); idle(5);
        add_frame(3, 8'h5A, 1'b0); expect_at(8, 1'b0, 8'h5A, 1); send(1'b0); idle(5);
        add_frame(8, 8'h77, 1'b0); expect_at(13, 1'b0, 8'h77, 1); send(1'b0); idle(5);

        // Back-to-back frames: second ID_1 arrives during S_CHECK.
        add_frame(1, 8'h11, 1'b0);
        add_frame(1, 8'h22, 1'b0);
        expect_at(6, 1'b0, 8'h11, 1);
        expect_at(13, 1'b0, 8'h22, 1);
        send(1'b1); idle(5);

        // ID mismatches: no pulses, no timeout while hunting.
        tx_q = {8'h01}; send(1'b0); idle(150);
        tx_q = {8'h00, 8'h01}; send(1'b0); idle(150);

        // Truncated frame: timeout TMO cycles after the last byte, then recovery.
        tx_q = {8'h00, 8'h00, 8'h00, 8'h01, 8'h3C};
        expect_at(4, 1'b1, 8'h22, TMO);
        send(1'b0); idle(TMO + 20);
        add_frame(1, 8'hC3, 1'b0); expect_at(6, 1'b0, 8'hC3, 1); send(1'b0); idle(5);

        // Reset mid-frame: frame discarded silently, cmd cleared.
        tx_q = {8'h00, 8'h00, 8'h00, 8'h01, 8'hD2}; send(1'b0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b1;
        check("rst_mid_cmd", {24'd0, cmd}, 0);
        check("rst_mid_cmd_flag", {31'd0, cmd_flag}, 0);
        check("rst_mid_frame_err", {31'd0, frame_err}, 0);
        idle(TMO + 50);
        add_frame(1, 8'h96, 1'b0); expect_at(6, 1'b0, 8'h96, 1); send(1'b0);

        for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge sys_clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_cmd", {24'd0, cmd}, 32'h96);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
